fft_frame_feeder: RTL and testbench
===================================

// Module: fft_frame_feeder
// PURPOSE
// - Front end of the speech path: captures one frame of mic/ADC samples after speech onset and buffers it.
// - Streams the frame into the FFT core's input port with a valid/ready handshake.
// - Pulses algo_start so the downstream energy classifier arms before the first FFT output appears.
// - The block sits between the audio sample source and the FFT core.
// PARAMETERS
// - DATA_W      16     sample width, two's complement
// - FRAME_LOG2  13     log2 frame length (8192 samples); must match the classifier's >>13 averaging
// - TRIG_LEVEL  16'd2000  onset threshold on |sample|
// PORTS
// - clk           in   1          clock; all logic posedge clk
// - rst           in   1          reset, synchronous, active-high
// - arm           in   1          pulse: start waiting for speech onset
// - sample_in     in   DATA_W     signed audio sample
// - sample_valid  in   1          sample_in valid this cycle (1-cycle strobe, any rate)
// - fft_rfd       in   1          FFT core ready for data
// - fft_start     out  1          1-cycle pulse, start FFT frame
// - fft_xn_re     out  DATA_W     sample to FFT
// - fft_xn_im     out  DATA_W     always 0
// - fft_xn_index  out  FRAME_LOG2 index of the current output sample
// - fft_xn_valid  out  1          fft_xn_* valid
// - algo_start    out  1          1-cycle pulse to the classifier's start input
// - busy          out  1          high in every state except IDLE and DONE
// - done          out  1          high in DONE, until next arm or rst
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, counters 0. Buffer RAM is not cleared.
// - Reset mid-operation aborts capture/stream at once, with no further fft_xn_valid.
// - Buffer: 2^FRAME_LOG2 x DATA_W RAM, 1 write port, synchronous read with 1-cycle latency.
// - IDLE: arm=1 -> ARMED.
// - ARMED: on sample_valid with |sample_in| >= TRIG_LEVEL, write that sample at addr 0 and go to CAPTURE with wr_cnt=1.
//   - |x| is computed DATA_W+1 wide, so -32768 -> 32768, which triggers.
// - CAPTURE: each sample_valid writes addr wr_cnt and increments it. When the write to addr 2^FRAME_LOG2-1 completes -> START.
//   - The write counter wraps to 0; no extra sample is stored.
// - START (1 cycle): fft_start=1 and algo_start=1 together -> STREAM, rd_addr=0.
// - STREAM: a beat transfers when fft_xn_valid && fft_rfd.
//   - Beats are in-order indices 0..2^FRAME_LOG2-1, with fft_xn_index equal to the RAM address of fft_xn_re.
//   - fft_rfd=0 holds fft_xn_* stable and stalls the read address. Prefetch/skid logic must absorb the 1-cycle RAM latency.
//   - Required result: no sample dropped or duplicated under arbitrary rfd toggling.
//   - With rfd held high, one beat per cycle. fft_xn_valid first rises within 2 cycles of START.
// - Final beat (index 2^FRAME_LOG2-1) transfers -> DONE; fft_xn_valid drops the next cycle.
// - DONE: done=1. arm=1 -> ARMED (done cleared same edge).
// - Simultaneous events:
//   - arm in any state other than IDLE/DONE is ignored.
//   - sample_valid outside ARMED/CAPTURE is ignored.
//   - sample_valid during START/STREAM is dropped, never written.
// - Total fft_start/algo_start pulses per frame: exactly one each.
// TESTING
// - T1 reset: rst high 3 cycles during STREAM -> all outputs 0 next cycle; idle; arm restarts cleanly.
// - T2 trigger: arm, then samples 100,-1999,2000 -> capture begins at 2000 (addr 0). Separately, -32768 also triggers.
// - T3 full frame: ramp samples after trigger, rfd=1 -> 8192 beats, re[k]=sample k, im=0, contiguous; then done=1.
// - T4 backpressure: random rfd (50%) -> beat sequence identical to T3, fft_xn_* stable while rfd=0.
// - T5 pulses: exactly one fft_start and algo_start, same cycle, before first fft_xn_valid.
//   - arm during CAPTURE has no effect; sample_valid during STREAM does not corrupt data.
// - T6 re-arm: arm in DONE -> second frame captured; its contents differ correctly from the first.

Source files
------------

// File: rtl/fft_frame_feeder_if.sv
// FFT core input port: frame start strobe, sample beat with index, and the
// core's ready-for-data backpressure.
interface fft_frame_feeder_if #(
    parameter int DATA_W     = 16,
    parameter int FRAME_LOG2 = 13
);
    logic                  fft_start;
    logic [DATA_W-1:0]     fft_xn_re;
    logic [DATA_W-1:0]     fft_xn_im;
    logic [FRAME_LOG2-1:0] fft_xn_index;
    logic                  fft_xn_valid;
    logic                  fft_rfd;

    modport master (
        output fft_start, fft_xn_re, fft_xn_im, fft_xn_index, fft_xn_valid,
        input  fft_rfd
    );

    modport slave (
        input  fft_start, fft_xn_re, fft_xn_im, fft_xn_index, fft_xn_valid,
        output fft_rfd
    );
endinterface

// File: rtl/fft_frame_feeder.sv
// Captures one frame of audio after speech onset into a buffer RAM, then
// streams it into the FFT core with valid/ready and a single start pulse.
module fft_frame_feeder #(
    parameter int                DATA_W     = 16,
    parameter int                FRAME_LOG2 = 13,
    parameter logic [DATA_W-1:0] TRIG_LEVEL = 16'd2000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arm,
    input  logic [DATA_W-1:0]    sample_in,
    input  logic                 sample_valid,
    fft_frame_feeder_if.master   fft,
    output logic                 algo_start,
    output logic                 busy,
    output logic                 done
);
    localparam int DEPTH = 1 << FRAME_LOG2;
    localparam logic [FRAME_LOG2-1:0] LAST_IDX = {FRAME_LOG2{1'b1}};
    localparam logic [FRAME_LOG2-1:0] ONE_IDX  = {{(FRAME_LOG2-1){1'b0}}, 1'b1};
    localparam logic [FRAME_LOG2:0]   ONE_CNT  = {{FRAME_LOG2{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        CAPTURE = 3'd2,
        START   = 3'd3,
        STREAM  = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t                state_r;
    logic [FRAME_LOG2-1:0] wr_cnt_r;
    logic [FRAME_LOG2:0]   rd_cnt_r;
    logic                  rd_pending_r;
    logic                  skid_valid_r;
    logic [DATA_W-1:0]     skid_data_r;
    logic [FRAME_LOG2-1:0] skid_idx_r;
    logic [DATA_W-1:0]     ram_q_r;
    logic [FRAME_LOG2-1:0] ram_idx_r;
    logic                  fft_start_r;
    logic                  xn_valid_r;
    logic [DATA_W-1:0]     xn_re_r;
    logic [FRAME_LOG2-1:0] xn_index_r;
    logic                  algo_start_r;
    logic                  busy_r;
    logic                  done_r;

    logic [DATA_W-1:0]     mem [DEPTH];

    logic [DATA_W:0]       mag_s;
    logic                  trig_s;
    logic                  wr_en_s;
    logic [FRAME_LOG2-1:0] wr_addr_s;
    logic [FRAME_LOG2-1:0] rd_addr_s;
    logic                  fire_s;
    logic [1:0]            occ_s;
    logic                  issue_s;

    // Sign-extend before negating so the most negative sample still has a magnitude.
    function automatic logic [DATA_W:0] magnitude(input logic [DATA_W-1:0] x);
        logic [DATA_W:0] ext;
        ext = {x[DATA_W-1], x};
        if (ext[DATA_W]) begin
            magnitude = ~ext + {{DATA_W{1'b0}}, 1'b1};
        end else begin
            magnitude = ext;
        end
    endfunction

    // Onset detect, buffer write decode and read-issue credit check
    always_comb begin
        mag_s     = magnitude(sample_in);
        trig_s    = (mag_s >= {1'b0, TRIG_LEVEL});
        wr_en_s   = 1'b0;
        wr_addr_s = '0;
        case (state_r)
            ARMED: begin
                if (sample_valid && trig_s) begin
                    wr_en_s = 1'b1;
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            CAPTURE: begin
                wr_en_s   = sample_valid;
                wr_addr_s = wr_cnt_r;
            end
            default: begin
                wr_en_s = 1'b0;
            end
        endcase
        rd_addr_s = rd_cnt_r[FRAME_LOG2-1:0];
        fire_s    = xn_valid_r && fft.fft_rfd;
        // Output register plus skid entry give two slots; a read in flight holds one.
        occ_s     = {1'b0, xn_valid_r} + {1'b0, skid_valid_r} + {1'b0, rd_pending_r};
        if ((state_r == START || state_r == STREAM) && !rd_cnt_r[FRAME_LOG2]) begin
            issue_s = ((occ_s - {1'b0, fire_s}) < 2'd2);
        end else begin
            issue_s = 1'b0;
        end
    end

    // Frame buffer: single write port, registered read
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[wr_addr_s] <= sample_in;
        end
        if (issue_s) begin
            ram_q_r   <= mem[rd_addr_s];
            ram_idx_r <= rd_addr_s;
        end
    end

    // Control FSM with the stream output register and skid entry
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            wr_cnt_r     <= '0;
            rd_cnt_r     <= '0;
            rd_pending_r <= 1'b0;
            skid_valid_r <= 1'b0;
            skid_data_r  <= '0;
            skid_idx_r   <= '0;
            fft_start_r  <= 1'b0;
            xn_valid_r   <= 1'b0;
            xn_re_r      <= '0;
            xn_index_r   <= '0;
            algo_start_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            fft_start_r  <= 1'b0;
            algo_start_r <= 1'b0;
            rd_pending_r <= issue_s;
            if (issue_s) begin
                rd_cnt_r <= rd_cnt_r + ONE_CNT;
            end
            case (state_r)
                IDLE, DONE: begin
                    if (arm) begin
                        state_r      <= ARMED;
                        busy_r       <= 1'b1;
                        done_r       <= 1'b0;
                        rd_cnt_r     <= '0;
                        skid_valid_r <= 1'b0;
                        xn_valid_r   <= 1'b0;
                    end
                end
                ARMED: begin
                    if (sample_valid && trig_s) begin
                        state_r  <= CAPTURE;
                        wr_cnt_r <= ONE_IDX;
                    end
                end
                CAPTURE: begin
                    if (sample_valid) begin
                        wr_cnt_r <= wr_cnt_r + ONE_IDX;
                        if (wr_cnt_r == LAST_IDX) begin
                            state_r      <= START;
                            fft_start_r  <= 1'b1;
                            algo_start_r <= 1'b1;
                        end
                    end
                end
                START: begin
                    state_r <= STREAM;
                end
                STREAM: begin
                    if (fire_s || !xn_valid_r) begin
                        if (skid_valid_r) begin
                            xn_valid_r   <= 1'b1;
                            xn_re_r      <= skid_data_r;
                            xn_index_r   <= skid_idx_r;
                            skid_valid_r <= rd_pending_r;
                            skid_data_r  <= ram_q_r;
                            skid_idx_r   <= ram_idx_r;
                        end else if (rd_pending_r) begin
                            xn_valid_r <= 1'b1;
                            xn_re_r    <= ram_q_r;
                            xn_index_r <= ram_idx_r;
                        end else begin
                            xn_valid_r <= 1'b0;
                        end
                    end else if (rd_pending_r) begin
                        skid_valid_r <= 1'b1;
                        skid_data_r  <= ram_q_r;
                        skid_idx_r   <= ram_idx_r;
                    end
                    if (fire_s && xn_index_r == LAST_IDX) begin
                        state_r    <= DONE;
                        xn_valid_r <= 1'b0;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign fft.fft_start    = fft_start_r;
    assign fft.fft_xn_re    = xn_re_r;
    assign fft.fft_xn_im    = '0;
    assign fft.fft_xn_index = xn_index_r;
    assign fft.fft_xn_valid = xn_valid_r;
    assign algo_start       = algo_start_r;
    assign busy             = busy_r;
    assign done             = done_r;
endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed bench for fft_frame_feeder: onset trigger, full-frame streaming with
// and without backpressure, start pulses, mid-stream reset and re-arm.
module tb_fft_frame_feeder;
    localparam int FRAME = 8192;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        algo_start;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    int beats, starts, algos, apart, early, lat;

    fft_frame_feeder_if #(.DATA_W(16), .FRAME_LOG2(13)) fif ();

    fft_frame_feeder #(.DATA_W(16), .FRAME_LOG2(13), .TRIG_LEVEL(16'd2000)) dut (
        .clk          (clk),
        .rst          (rst),
        .arm          (arm),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .fft          (fif.master),
        .algo_start   (algo_start),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Frame 0: ramp from 2000, frame 1: descending by 7 from -5000, frame 2: -32768 then k
    function automatic logic [15:0] frame_val(input int which, input int k);
        int t;
        case (which)
            0:       t = 2000 + k;
            1:       t = -5000 - 7 * k;
            default: t = (k == 0) ? -32768 : k;
        endcase
        return t[15:0];
    endfunction

    task automatic send_sample(input logic [15:0] v);
        sample_in    = v;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic capture_frame(input int which, input bit gaps, input int arm_at);
        for (int k = 0; k < FRAME; k++) begin
            if (gaps && k < 64) step();
            arm = (k == arm_at);
            send_sample(frame_val(which, k));
            arm = 1'b0;
        end
    endtask

    task automatic run_stream(input int which, input bit rnd, input bit inject, input int stop,
                              output int nb, output int ns, output int na, output int nap,
                              output int ne, output int lt);
        logic        prev_stall;
        logic [15:0] prev_re;
        logic [12:0] prev_idx;
        int          start_cyc;
        int          first_cyc;
        nb = 0; ns = 0; na = 0; nap = 0; ne = 0;
        prev_stall = 1'b0; prev_re = '0; prev_idx = '0;
        start_cyc = -1; first_cyc = -1;
        for (int cyc = 0; cyc < 40000; cyc++) begin
            if (fif.fft_start) begin ns++; start_cyc = cyc; end
            if (algo_start) na++;
            if (fif.fft_start != algo_start) nap++;
            if (fif.fft_xn_valid) begin
                if (ns == 0) ne++;
                if (first_cyc < 0) first_cyc = cyc;
            end
            if (prev_stall) begin
                check_val("hold_valid", fif.fft_xn_valid, 1);
                check_val("hold_re", fif.fft_xn_re, prev_re);
                check_val("hold_idx", fif.fft_xn_index, prev_idx);
            end
            if (done || nb >= stop) break;
            arm = inject && (cyc == 100);
            if (inject) begin
                sample_valid = 1'b1;
                sample_in    = 16'($urandom);
            end
            fif.fft_rfd = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (fif.fft_xn_valid && fif.fft_rfd) begin
                check_val("beat_idx", fif.fft_xn_index, nb);
                check_val("beat_re", fif.fft_xn_re, frame_val(which, nb));
                check_val("beat_im", fif.fft_xn_im, 0);
                nb++;
            end
            prev_stall = fif.fft_xn_valid && !fif.fft_rfd;
            prev_re    = fif.fft_xn_re;
            prev_idx   = fif.fft_xn_index;
            step();
        end
        arm          = 1'b0;
        sample_valid = 1'b0;
        lt = first_cyc - start_cyc;
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; sample_in = '0; sample_valid = 1'b0; fif.fft_rfd = 1'b0;
        step(); step(); step();
        check_val("rst_valid", fif.fft_xn_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        rst = 1'b0;
        step();

        // T1: most negative sample triggers; reset mid-stream aborts
        arm = 1'b1; step(); arm = 1'b0;
        send_sample(16'd5);
        capture_frame(2, 1'b0, -1);
        run_stream(2, 1'b0, 1'b0, 20, beats, starts, algos, apart, early, lat);
        check_val("t1_beats", beats, 20);
        check_val("t1_busy", busy, 1);
        rst = 1'b1;
        step();
        check_val("t1_rst_valid", fif.fft_xn_valid, 0);
        check_val("t1_rst_start", fif.fft_start, 0);
        check_val("t1_rst_algo", algo_start, 0);
        check_val("t1_rst_busy", busy, 0);
        check_val("t1_rst_done", done, 0);
        check_val("t1_rst_idx", fif.fft_xn_index, 0);
        check_val("t1_rst_re", fif.fft_xn_re, 0);
        step(); step();
        rst = 1'b0;
        step(); step();
        check_val("t1_post_valid", fif.fft_xn_valid, 0);
        check_val("t1_post_busy", busy, 0);

        // T2/T3/T5: sub-threshold samples ignored, 2000 triggers, arm in CAPTURE ignored
        arm = 1'b1; step(); arm = 1'b0;
        check_val("t2_armed_busy", busy, 1);
        send_sample(16'd100);
        send_sample(16'hF831);
        check_val("t2_no_trig_start", fif.fft_start, 0);
        capture_frame(0, 1'b0, 100);
        run_stream(0, 1'b0, 1'b0, FRAME + 1, beats, starts, algos, apart, early, lat);
        check_val("t3_beats", beats, FRAME);
        check_val("t3_done", done, 1);
        check_val("t3_busy", busy, 0);
        check_val("t3_valid_drop", fif.fft_xn_valid, 0);
        check_val("t5_starts", starts, 1);
        check_val("t5_algos", algos, 1);
        check_val("t5_same_cycle", apart, 0);
        check_val("t5_early_valid", early, 0);
        check_val("t3_latency_le2", (lat >= 0 && lat <= 2), 1);
        step(); step(); step();
        check_val("t3_done_hold", done, 1);

        // T4/T6: re-arm, gappy capture, random backpressure, ignored inputs during stream
        arm = 1'b1; step(); arm = 1'b0;
        check_val("t6_done_clr", done, 0);
        check_val("t6_busy", busy, 1);
        capture_frame(1, 1'b1, -1);
        run_stream(1, 1'b1, 1'b1, FRAME + 1, beats, starts, algos, apart, early, lat);
        check_val("t4_beats", beats, FRAME);
        check_val("t4_done", done, 1);
        check_val("t4_starts", starts, 1);
        check_val("t4_algos", algos, 1);
        check_val("t4_same_cycle", apart, 0);
        check_val("t4_early_valid", early, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
